transfer_sequencer: RTL and testbench

//   Top-level controller for the UART->FIFO->parallel-out path. Sequences
//   COM_to_FIFO and FIFO_to_out strictly one after the other per transfer.

---
 rtl/transfer_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_transfer_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transfer_sequencer.sv
// Purpose: sequences the UART->FIFO->parallel-out path one phase after another, gating drain on CRC/length checks.
// Latency: start sampled at edge N -> fifo_clear high during cycle N+1, com_enable high during cycle N+2; every output is a register.
// Backpressure: none; strobes are counted as they arrive, start is ignored while busy, abort overrides any non-IDLE transition.
module transfer_sequencer #(
    parameter int TIMEOUT_CYCLES = 4095,    // idle cycles tolerated in RECEIVE/DRAIN
    parameter int TIMEOUT_W      = 12,      // must be wide enough to hold TIMEOUT_CYCLES
    parameter int MIN_BYTES      = 1,       // fewest bytes a transfer may carry
    parameter bit CRC_CHECK      = 1'b1     // require a zero CRC residue before draining
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       com_finish,
    input  logic [3:0] com_error,
    input  logic [7:0] crc,
    input  logic       fifo_we,
    input  logic       fifo_empty,
    input  logic       out_start,
    input  logic       out_finish,
    output logic       com_enable,
    output logic       out_enable,
    output logic       fifo_clear,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] err_code,
    output logic [9:0] rx_bytes,
    output logic [9:0] tx_bytes,
    output logic [2:0] state
);

    // State encoding is visible on the debug display, so the values are fixed.
    typedef enum logic [2:0] {
        stIdle    = 3'd0,
        stClear   = 3'd1,
        stReceive = 3'd2,
        stCheck   = 3'd3,
        stDrain   = 3'd4,
        stDone    = 3'd5,
        stFault   = 3'd6
    } seqState_e;

    // Fault causes reported on err_code.
    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_COM_ERR  = 3'd1;
    localparam logic [2:0] FC_RX_TMO   = 3'd2;
    localparam logic [2:0] FC_SHORT    = 3'd3;
    localparam logic [2:0] FC_CRC      = 3'd4;
    localparam logic [2:0] FC_COUNT    = 3'd5;
    localparam logic [2:0] FC_TX_TMO   = 3'd6;
    localparam logic [2:0] FC_ABORT    = 3'd7;

    localparam logic [9:0]           CNT_MAX     = 10'd1023;
    localparam logic [9:0]           MIN_CNT     = 10'(MIN_BYTES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_ONE = TIMEOUT_W'(1);

    seqState_e            curState;
    seqState_e            nextState;
    logic [2:0]           nextCode;
    logic [TIMEOUT_W-1:0] timeoutCnt;
    logic                 timedOut;
    logic                 watching;
    logic                 strobe;
    logic                 rxInc;
    logic                 txInc;
    logic [9:0]           rxNext;
    logic [9:0]           txNext;

    assign state = curState;

    // Only the strobe belonging to the current phase counts; the other one is
    // meaningless there. A strobe in the same cycle as a transition still counts.
    assign rxInc  = (curState == stReceive) && fifo_we   && (rx_bytes != CNT_MAX);
    assign txInc  = (curState == stDrain)   && out_start && (tx_bytes != CNT_MAX);
    assign rxNext = rx_bytes + {9'd0, rxInc};
    assign txNext = tx_bytes + {9'd0, txInc};

    // The idle timer only runs in the two phases that wait on the outside world.
    assign watching = (curState == stReceive) || (curState == stDrain);
    assign strobe   = ((curState == stReceive) && fifo_we) ||
                      ((curState == stDrain)   && out_start);
    assign timedOut = (timeoutCnt == TIMEOUT_MAX);

    // Next-state and next fault-code selection; abort is applied last so it wins.
    always_comb begin
        nextState = curState;
        nextCode  = err_code;
        case (curState)
            stIdle: begin
                if (start) begin
                    nextState = stClear;
                end
            end
            stClear: begin
                nextState = stReceive;
            end
            stReceive: begin
                if (com_finish) begin
                    if (com_error != 4'd0) begin
                        nextState = stFault;
                        nextCode  = FC_COM_ERR;
                    end else begin
                        nextState = stCheck;
                    end
                end else if (timedOut) begin
                    nextState = stFault;
                    nextCode  = FC_RX_TMO;
                end
            end
            stCheck: begin
                if (rx_bytes < MIN_CNT) begin
                    nextState = stFault;
                    nextCode  = FC_SHORT;
                end else if (CRC_CHECK && (crc != 8'h00)) begin
                    nextState = stFault;
                    nextCode  = FC_CRC;
                end else begin
                    nextState = stDrain;
                end
            end
            stDrain: begin
                // Compare against the count including a strobe landing this
                // very cycle, so the last byte is never missed.
                if (fifo_empty && out_finish) begin
                    if (txNext == rx_bytes) begin
                        nextState = stDone;
                    end else begin
                        nextState = stFault;
                        nextCode  = FC_COUNT;
                    end
                end else if (timedOut) begin
                    nextState = stFault;
                    nextCode  = FC_TX_TMO;
                end
            end
            stDone: begin
                nextState = stIdle;
            end
            stFault: begin
                if (start) begin
                    nextState = stClear;
                end
            end
            default: begin
                nextState = stIdle;
                nextCode  = FC_NONE;
            end
        endcase

        // A held abort keeps the block parked in FAULT; the original cause is
        // kept if we were already faulted.
        if (abort && (curState != stIdle)) begin
            nextState = stFault;
            if (curState != stFault) begin
                nextCode = FC_ABORT;
            end
        end

        // A new run starts with a clean fault report.
        if (nextState == stClear) begin
            nextCode = FC_NONE;
        end
    end

    // State register with outputs decoded from the upcoming state, so each
    // output changes on the same edge as the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            curState   <= stIdle;
            err_code   <= FC_NONE;
            fifo_clear <= 1'b0;
            com_enable <= 1'b0;
            out_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            curState   <= nextState;
            err_code   <= nextCode;
            fifo_clear <= (nextState == stClear);
            com_enable <= (nextState == stReceive);
            out_enable <= (nextState == stDrain);
            busy       <= (nextState != stIdle) && (nextState != stFault);
            done       <= (nextState == stDone);
            err        <= (nextState == stFault);
        end
    end

    // Byte counters and idle timer; all three start from zero for a new run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_bytes   <= 10'd0;
            tx_bytes   <= 10'd0;
            timeoutCnt <= '0;
        end else if (nextState == stClear) begin
            rx_bytes   <= 10'd0;
            tx_bytes   <= 10'd0;
            timeoutCnt <= '0;
        end else begin
            rx_bytes <= rxNext;
            tx_bytes <= txNext;
            if ((nextState != curState) || strobe) begin
                timeoutCnt <= '0;
            end else if (watching && !timedOut) begin
                timeoutCnt <= timeoutCnt + TIMEOUT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_transfer_sequencer.sv
// Purpose: self-checking bench for transfer_sequencer: vector table, corner-case sequences, randomized transfers vs. a transfer-level model.
// Latency: inputs are driven 1 ns after a rising edge and outputs sampled 1 ns after the next rising edge.
// Backpressure: not applicable; every wait on the design is bounded by a cycle budget or the watchdog.
module tb_transfer_sequencer;

    localparam int TO = 40;

    logic       clk_raw = 1'b0;
    logic       reset;
    logic       start, abort, com_finish, fifo_we, fifo_empty, out_start, out_finish;
    logic [3:0] com_error;
    logic [7:0] crc;
    logic       com_enable, out_enable, fifo_clear, busy, done, err;
    logic [2:0] err_code, state;
    logic [9:0] rx_bytes, tx_bytes;

    int checks   = 0;
    int failures = 0;

    transfer_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_W(6),
        .MIN_BYTES(1),
        .CRC_CHECK(1'b1)
    ) dut (
        .clk(clk_raw), .reset(reset), .start(start), .abort(abort),
        .com_finish(com_finish), .com_error(com_error), .crc(crc),
        .fifo_we(fifo_we), .fifo_empty(fifo_empty), .out_start(out_start),
        .out_finish(out_finish), .com_enable(com_enable), .out_enable(out_enable),
        .fifo_clear(fifo_clear), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .rx_bytes(rx_bytes), .tx_bytes(tx_bytes), .state(state)
    );

    always #5 clk_raw = ~clk_raw;

    typedef struct {
        logic       start, abort, comFinish;
        logic [3:0] comError;
        logic [7:0] crc;
        logic       fifoWe, fifoEmpty, outStart, outFinish;
        logic [2:0] expState;
        logic       expComEn, expOutEn, expClear, expBusy, expDone, expErr;
        logic [2:0] expCode;
        logic [9:0] expRx, expTx;
    } vec_t;

    function automatic vec_t mk(int st, int ab, int cf, int ce, int cr, int we, int fe, int os, int ofin,
                                int s, int cen, int oen, int clr, int bsy, int dn, int er, int code, int rx, int tx);
        vec_t r;
        r.start = st[0];  r.abort = ab[0];  r.comFinish = cf[0];
        r.comError = 4'(ce);  r.crc = 8'(cr);
        r.fifoWe = we[0];  r.fifoEmpty = fe[0];  r.outStart = os[0];  r.outFinish = ofin[0];
        r.expState = 3'(s);  r.expComEn = cen[0];  r.expOutEn = oen[0];  r.expClear = clr[0];
        r.expBusy = bsy[0];  r.expDone = dn[0];  r.expErr = er[0];  r.expCode = 3'(code);
        r.expRx = 10'(rx);  r.expTx = 10'(tx);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic clearIn();
        start = 0; abort = 0; com_finish = 0; com_error = 4'd0; crc = 8'd0;
        fifo_we = 0; fifo_empty = 0; out_start = 0; out_finish = 0;
    endtask

    task automatic step();
        @(posedge clk_raw);
        #1;
    endtask

    task automatic doReset();
        clearIn();
        reset = 0;
        step();
        step();
        reset = 1;
        step();
    endtask

    task automatic beginRx();
        start = 1; step(); start = 0; step();
    endtask

    task automatic rxBytes(int n);
        for (int i = 0; i < n; i++) begin fifo_we = 1; step(); end
        fifo_we = 0;
    endtask

    task automatic txBytes(int n);
        for (int i = 0; i < n; i++) begin out_start = 1; step(); end
        out_start = 0;
    endtask

    task automatic toDrain(int n);
        beginRx();
        rxBytes(n);
        com_finish = 1; step(); com_finish = 0;
        crc = 8'h00; step();
    endtask

    // One randomized transfer; expected outcome follows the rule priority
    // abort > COM error > length > CRC > byte-count agreement.
    task automatic randomTransfer(int idx);
        int n, nSent, abortDrain, sel, expCode, expRx, expTx;
        bit abortRx;
        logic [3:0] cerr;
        logic [7:0] c;
        n = $urandom_range(0, 6); nSent = n; abortDrain = -1; abortRx = 0; cerr = 4'd0; c = 8'd0;
        sel = $urandom_range(0, 9);
        case (sel)
            0: cerr = 4'($urandom_range(1, 15));
            1: c = 8'($urandom_range(1, 255));
            2: nSent = (n > 0 && $urandom_range(0, 1) == 1) ? n - 1 : n + 1;
            3: abortRx = 1;
            4: if (n > 0) abortDrain = $urandom_range(0, n - 1);
            default: ;
        endcase

        expRx = n; expTx = 0;
        if (abortRx)             expCode = 7;
        else if (cerr != 4'd0)   expCode = 1;
        else if (n < 1)          expCode = 3;
        else if (c != 8'd0)      expCode = 4;
        else if (abortDrain >= 0) begin expCode = 7; expTx = abortDrain + 1; end
        else begin expTx = nSent; expCode = (nSent == n) ? 0 : 5; end

        start = 1; step(); start = 0;
        chk($sformatf("rnd%0d_clear_state", idx), 32'(state), 32'd1);
        chk($sformatf("rnd%0d_fifo_clear", idx), 32'(fifo_clear), 32'd1);
        step();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) step();
            fifo_we = 1; step(); fifo_we = 0;
        end
        repeat ($urandom_range(0, 3)) step();
        com_finish = 1; com_error = cerr; crc = c; abort = abortRx;
        step();
        com_finish = 0; com_error = 4'd0; abort = 0;
        if (state == 3'd3) begin
            step();
            crc = 8'd0;
            if (state == 3'd4) begin
                for (int j = 0; j < nSent; j++) begin
                    repeat ($urandom_range(0, 3)) step();
                    out_start = 1;
                    if (j == abortDrain) abort = 1;
                    step();
                    out_start = 0;
                    if (abort) begin abort = 0; break; end
                end
                if (state == 3'd4) begin
                    fifo_empty = 1; out_finish = 1; step(); fifo_empty = 0; out_finish = 0;
                end
            end
        end
        crc = 8'd0;

        if (expCode == 0) begin
            chk($sformatf("rnd%0d_done_state", idx), 32'(state), 32'd5);
            chk($sformatf("rnd%0d_done_pulse", idx), 32'(done), 32'd1);
            chk($sformatf("rnd%0d_rx", idx), 32'(rx_bytes), 32'(expRx));
            chk($sformatf("rnd%0d_tx", idx), 32'(tx_bytes), 32'(expTx));
            step();
            chk($sformatf("rnd%0d_idle_state", idx), 32'(state), 32'd0);
            chk($sformatf("rnd%0d_done_drop", idx), 32'(done), 32'd0);
        end else begin
            chk($sformatf("rnd%0d_fault_state", idx), 32'(state), 32'd6);
            chk($sformatf("rnd%0d_err_code", idx), 32'(err_code), 32'(expCode));
            chk($sformatf("rnd%0d_err", idx), 32'(err), 32'd1);
            chk($sformatf("rnd%0d_rx", idx), 32'(rx_bytes), 32'(expRx));
            chk($sformatf("rnd%0d_tx", idx), 32'(tx_bytes), 32'(expTx));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   n;

        clearIn();
        reset = 0;
        #1;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_com_enable", 32'(com_enable), 32'd0);
        chk("reset_rx", 32'(rx_bytes), 32'd0);
        step(); step();
        reset = 1;
        step();

        // IDLE ignores everything but start
        abort = 1; com_finish = 1; fifo_we = 1; step(); clearIn();
        chk("idle_ignore_state", 32'(state), 32'd0);
        chk("idle_ignore_rx", 32'(rx_bytes), 32'd0);

        //            st ab cf ce cr   we fe os of   S cen oen clr bsy dn er code rx tx
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   1, 0, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0,   1, 0, 0, 0,   3, 0, 0, 0, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   4, 0, 1, 0, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 1, 0,   4, 0, 1, 0, 1, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 1, 0,   4, 0, 1, 0, 1, 0, 0, 0, 3, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 1, 0,   4, 0, 1, 0, 1, 0, 0, 0, 3, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 1, 0, 1,   5, 0, 0, 0, 1, 1, 0, 0, 3, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 3, 3));
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 2, 0,   0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,   1, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0,   0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 1, 7, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0,   0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 1, 7, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0,   0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   2, 1, 0, 0, 1, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            start = vecs[i].start; abort = vecs[i].abort; com_finish = vecs[i].comFinish;
            com_error = vecs[i].comError; crc = vecs[i].crc; fifo_we = vecs[i].fifoWe;
            fifo_empty = vecs[i].fifoEmpty; out_start = vecs[i].outStart; out_finish = vecs[i].outFinish;
            step();
            chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].expState));
            chk($sformatf("vec%0d_com_enable", i), 32'(com_enable), 32'(vecs[i].expComEn));
            chk($sformatf("vec%0d_out_enable", i), 32'(out_enable), 32'(vecs[i].expOutEn));
            chk($sformatf("vec%0d_fifo_clear", i), 32'(fifo_clear), 32'(vecs[i].expClear));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].expDone));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].expErr));
            chk($sformatf("vec%0d_err_code", i), 32'(err_code), 32'(vecs[i].expCode));
            chk($sformatf("vec%0d_rx", i), 32'(rx_bytes), 32'(vecs[i].expRx));
            chk($sformatf("vec%0d_tx", i), 32'(tx_bytes), 32'(vecs[i].expTx));
        end
        clearIn();

        // zero bytes received -> length fault after CHECK
        doReset(); beginRx();
        com_finish = 1; step(); com_finish = 0;
        chk("short_check_state", 32'(state), 32'd3);
        step();
        chk("short_fault_state", 32'(state), 32'd6);
        chk("short_err_code", 32'(err_code), 32'd3);

        // bad CRC residue, then restart straight from FAULT
        doReset(); beginRx(); rxBytes(5);
        com_finish = 1; crc = 8'hA7; step(); com_finish = 0; step(); crc = 8'h00;
        chk("crc_fault_state", 32'(state), 32'd6);
        chk("crc_err_code", 32'(err_code), 32'd4);
        chk("crc_rx", 32'(rx_bytes), 32'd5);
        start = 1; step(); start = 0;
        chk("restart_state", 32'(state), 32'd1);
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_err_code", 32'(err_code), 32'd0);
        chk("restart_fifo_clear", 32'(fifo_clear), 32'd1);
        step();
        chk("restart_clear_drop", 32'(fifo_clear), 32'd0);
        chk("restart_rx_zeroed", 32'(rx_bytes), 32'd0);

        // RECEIVE idle timeout: TO idle cycles tolerated, fault on the next one
        doReset(); beginRx(); rxBytes(2);
        n = 0;
        while (state == 3'd2 && n < 4 * TO) begin step(); n++; end
        chk("rx_timeout_cycles", 32'(n), 32'(TO + 1));
        chk("rx_timeout_code", 32'(err_code), 32'd2);
        chk("rx_timeout_rx", 32'(rx_bytes), 32'd2);

        // DRAIN idle timeout
        doReset(); toDrain(1);
        chk("drain_entry_state", 32'(state), 32'd4);
        n = 0;
        while (state == 3'd4 && n < 4 * TO) begin step(); n++; end
        chk("drain_timeout_cycles", 32'(n), 32'(TO + 1));
        chk("drain_timeout_code", 32'(err_code), 32'd6);
        chk("drain_timeout_out_en", 32'(out_enable), 32'd0);

        // abort beats a simultaneous com_finish; the byte in that cycle counts
        doReset(); beginRx(); rxBytes(2);
        abort = 1; com_finish = 1; fifo_we = 1; step(); clearIn();
        chk("abort_rx_state", 32'(state), 32'd6);
        chk("abort_rx_code", 32'(err_code), 32'd7);
        chk("abort_rx_count", 32'(rx_bytes), 32'd3);
        chk("abort_rx_com_en", 32'(com_enable), 32'd0);

        // drained fewer bytes than received
        doReset(); toDrain(2); txBytes(1);
        fifo_empty = 1; out_finish = 1; step(); clearIn();
        chk("mismatch_state", 32'(state), 32'd6);
        chk("mismatch_code", 32'(err_code), 32'd5);
        chk("mismatch_tx", 32'(tx_bytes), 32'd1);

        // both counters saturate at 1023
        doReset(); beginRx(); rxBytes(1030);
        chk("rx_saturate", 32'(rx_bytes), 32'd1023);
        com_finish = 1; step(); com_finish = 0; step();
        txBytes(1030);
        chk("tx_saturate", 32'(tx_bytes), 32'd1023);
        fifo_empty = 1; out_finish = 1; step(); clearIn();
        chk("saturate_done_state", 32'(state), 32'd5);
        chk("saturate_done_pulse", 32'(done), 32'd1);

        // asynchronous reset in the middle of DRAIN
        doReset(); toDrain(2); txBytes(1);
        #3; reset = 0; #1;
        chk("async_reset_state", 32'(state), 32'd0);
        chk("async_reset_out_en", 32'(out_enable), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_rx", 32'(rx_bytes), 32'd0);
        chk("async_reset_tx", 32'(tx_bytes), 32'd0);
        #2; reset = 1;
        step();

        // randomized transfers against the transfer-level model
        doReset();
        for (int t = 0; t < 40; t++) randomTransfer(t);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
